vram_arbiter: RTL and testbench

Time-multiplexes the single-port 8 KiB frame buffer between the VGA scan-out and the 6502 bus. The block generates the `cpu_clk` phase signal consumed by the VGA stage, serves one video read per low phase and one CPU access per high phase, and returns registered video data on `vid_data`, which feeds the VGA `data_in`. An optional power-on clear engine zeroes the frame buffer after reset.

---
 rtl/vram_pkg.sv | 18 +
 rtl/vram_sp.sv | 24 ++
 rtl/vram_arbiter.sv | 125 ++++++++++++
 tb/tb_vram_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared constants for the frame-buffer arbiter: state encodings, slot meaning, default widths.
package vram_pkg;

  localparam int unsigned DEFAULT_AW = 13;
  localparam int unsigned DEFAULT_DW = 8;

  // cpu_clk value that owns the RAM port
  localparam logic SLOT_VIDEO = 1'b0;
  localparam logic SLOT_CPU   = 1'b1;

  typedef logic [1:0] vram_state_t;

  localparam vram_state_t ST_CLEAR = 2'd0;
  localparam vram_state_t ST_IDLE  = 2'd1;
  localparam vram_state_t ST_PEND  = 2'd2;
  localparam vram_state_t ST_ACK   = 2'd3;

endpackage

// File: rtl/vram_sp.sv
// Single-port synchronous frame-buffer RAM; one-cycle read, read-during-write returns old data.
module vram_sp
  import vram_pkg::*;
#(
  parameter int unsigned AW = DEFAULT_AW,
  parameter int unsigned DW = DEFAULT_DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/vram_arbiter.sv
// Splits the single RAM port between video reads (cpu_clk=0) and CPU/clear accesses (cpu_clk=1),
// with an optional power-on clear of the whole frame buffer.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned   AW           = DEFAULT_AW,
  parameter int unsigned   DW           = DEFAULT_DW,
  parameter bit            CLEAR_ON_RST = 1'b1,
  parameter logic [DW-1:0] CLEAR_VALUE  = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          cpu_clk,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          busy
);

  localparam vram_state_t ST_RESET = CLEAR_ON_RST ? ST_CLEAR : ST_IDLE;

  logic          phase_q;
  vram_state_t   state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          req_we_q;
  logic [AW-1:0] req_addr_q;
  logic [DW-1:0] req_wdata_q;
  logic [DW-1:0] vid_hold_q;
  logic [DW-1:0] rdata_hold_q;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          ack_rd;

  vram_sp #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (phase_q == SLOT_CPU) begin
          clr_cnt_d = clr_cnt_q + AW'(1);
          if (&clr_cnt_q) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_IDLE: if (cpu_req) state_d = ST_PEND;
      ST_PEND: if (phase_q == SLOT_CPU) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Writes are gated by rst so an access landing in the reset cycle never reaches the array.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = vid_addr;
    ram_wdata = req_wdata_q;
    if (phase_q == SLOT_CPU) begin
      if (state_q == ST_CLEAR) begin
        ram_addr  = clr_cnt_q;
        ram_wdata = CLEAR_VALUE;
        ram_we    = ~rst;
      end else begin
        ram_addr = req_addr_q;
        ram_we   = (state_q == ST_PEND) && req_we_q && !rst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= SLOT_VIDEO;
      state_q      <= ST_RESET;
      clr_cnt_q    <= '0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      vid_hold_q   <= '0;
      rdata_hold_q <= '0;
    end else begin
      phase_q   <= ~phase_q;
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      if (state_q == ST_IDLE && cpu_req) begin
        req_we_q    <= cpu_we;
        req_addr_q  <= cpu_addr;
        req_wdata_q <= cpu_wdata;
      end
      // RAM output is overwritten by the CPU slot, so keep the video byte for the next low cycle.
      if (phase_q == SLOT_CPU) begin
        vid_hold_q <= ram_rdata;
      end
      if (ack_rd) begin
        rdata_hold_q <= ram_rdata;
      end
    end
  end

  assign ack_rd    = (state_q == ST_ACK) && !req_we_q;
  assign cpu_clk   = phase_q;
  assign vid_data  = (phase_q == SLOT_CPU) ? ram_rdata : vid_hold_q;
  assign cpu_rdata = ack_rd ? ram_rdata : rdata_hold_q;
  assign cpu_ack   = (state_q == ST_ACK);
  assign busy      = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter: one instance with power-on clear, one without,
// both checked against a flat memory model and the phase/latency rules.
module tb_vram_arbiter;

  localparam int unsigned NWORDS = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, sel_a;
  logic [12:0] vid_addr, cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_req, cpu_we;

  logic       cpu_clk_a, cpu_ack_a, busy_a, cpu_clk_b, cpu_ack_b, busy_b;
  logic [7:0] vid_data_a, cpu_rdata_a, vid_data_b, cpu_rdata_b;

  logic       ph, ack, bsy, rst_cur;
  logic [7:0] vdat, rdat;

  int         n_checks, n_errors, cyc, acks;
  logic [7:0] model [NWORDS];
  bit         known [NWORDS];
  bit         vchk_en, vid_walk;

  vram_arbiter #(
    .AW           (13),
    .DW           (8),
    .CLEAR_ON_RST (1'b1),
    .CLEAR_VALUE  (8'h00)
  ) dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .cpu_clk   (cpu_clk_a),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data_a),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata_a),
    .cpu_ack   (cpu_ack_a),
    .busy      (busy_a)
  );

  vram_arbiter #(
    .AW           (13),
    .DW           (8),
    .CLEAR_ON_RST (1'b0),
    .CLEAR_VALUE  (8'h00)
  ) dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .cpu_clk   (cpu_clk_b),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data_b),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata_b),
    .cpu_ack   (cpu_ack_b),
    .busy      (busy_b)
  );

  assign ph      = sel_a ? cpu_clk_a   : cpu_clk_b;
  assign ack     = sel_a ? cpu_ack_a   : cpu_ack_b;
  assign bsy     = sel_a ? busy_a      : busy_b;
  assign vdat    = sel_a ? vid_data_a  : vid_data_b;
  assign rdat    = sel_a ? cpu_rdata_a : cpu_rdata_b;
  assign rst_cur = sel_a ? rst_a       : rst_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // cyc counts cycles since the last reset release, so cyc[0] is the expected cpu_clk.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (vid_walk) begin
      if (!cyc[0]) vid_addr = vid_addr + 13'd1;
    end else begin
      vid_addr = 13'($urandom_range(0, 31));
    end
  endtask

  task automatic release_reset(input bit which_a);
    tick();
    if (which_a) rst_a = 1'b0;
    else rst_b = 1'b0;
    cyc = 0;
  endtask

  task automatic check_reset(input bit exp_busy);
    check_eq("rst_cpu_clk", ph, 1'b0);
    check_eq("rst_vid_data", vdat, 8'h00);
    check_eq("rst_cpu_rdata", rdat, 8'h00);
    check_eq("rst_cpu_ack", ack, 1'b0);
    check_eq("rst_busy", bsy, exp_busy);
  endtask

  task automatic cpu_op(input logic we, input logic [12:0] addr, input logic [7:0] wdata);
    int   n;
    logic ph_exp;
    ph_exp = cyc[0];
    check_eq("req_phase", ph, ph_exp);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    n = 0;
    do begin tick(); n++; end while (!ack && n < 8);
    check_eq("ack_latency", n, ph_exp ? 3 : 2);
    if (we) begin
      model[addr] = wdata;
      known[addr] = 1'b1;
    end else if (known[addr]) begin
      check_eq("cpu_rdata", rdat, model[addr]);
    end
    cpu_req = 1'b0;
    tick();
    check_eq("ack_pulse", ack, 1'b0);
    if (!we && known[addr]) check_eq("rdata_hold", rdat, model[addr]);
  endtask

  task automatic run_clear(input bit with_req);
    int n, m;
    n = 0;
    acks = 0;
    while (bsy && n < 20000) begin
      if (with_req && n == 100) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0005; cpu_wdata = 8'h77;
      end
      tick();
      n++;
      if (ack) acks++;
    end
    check_eq("clr_len", n, 16384);
    for (int i = 0; i < NWORDS; i++) begin
      model[i] = 8'h00;
      known[i] = 1'b1;
    end
    if (with_req) begin
      check_eq("clr_no_ack", acks, 0);
      m = 0;
      while (!ack && m < 8) begin tick(); m++; end
      check_eq("clr_req_lat", m, 2);
      model[5] = 8'h77;
      cpu_req = 1'b0;
      tick();
      check_eq("clr_req_pulse", ack, 1'b0);
    end
  endtask

  // Video checker: address seen in a low slot must show in the next high slot and the low after.
  initial begin : vid_checker
    logic [7:0] exp_v;
    bit         have;
    have  = 1'b0;
    exp_v = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst_cur || !vchk_en) begin
        have = 1'b0;
      end else if (cyc[0]) begin
        if (have) check_eq("vid_data", vdat, exp_v);
      end else begin
        if (have) check_eq("vid_hold", vdat, exp_v);
        have  = known[vid_addr];
        exp_v = model[vid_addr];
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    n_checks = 0; n_errors = 0; cyc = 0; acks = 0;
    rst_a = 1'b1; rst_b = 1'b1; sel_a = 1'b1; vchk_en = 1'b0; vid_walk = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; vid_addr = '0;
    for (int i = 0; i < NWORDS; i++) begin
      model[i] = 8'h00;
      known[i] = 1'b0;
    end
    repeat (3) tick();

    // Instance with clear: first clear, preload 0xFF, reset, clear again with a blocked request.
    release_reset(1'b1);
    check_reset(1'b1);
    run_clear(1'b0);
    vchk_en = 1'b1;
    for (int i = 0; i < NWORDS; i += 8) cpu_op(1'b1, 13'(i), 8'hFF);
    cpu_op(1'b1, 13'h1FFF, 8'hFF);
    cpu_op(1'b0, 13'h0008, 8'h00);
    vchk_en = 1'b0;
    rst_a = 1'b1;
    tick();
    release_reset(1'b1);
    check_reset(1'b1);
    run_clear(1'b1);
    vchk_en = 1'b1;
    if (cyc[0]) tick();
    vid_walk = 1'b1;
    vid_addr = 13'h0000;
    repeat (2 * NWORDS + 2) tick();
    vid_walk = 1'b0;

    // Instance without clear.
    vchk_en = 1'b0;
    rst_a = 1'b1;
    sel_a = 1'b0;
    for (int i = 0; i < NWORDS; i++) known[i] = 1'b0;
    release_reset(1'b0);
    check_reset(1'b0);
    vchk_en = 1'b1;
    for (int i = 0; i < 32; i++) cpu_op(1'b1, 13'(i), 8'($urandom));
    cpu_op(1'b1, 13'h1FFF, 8'h3C);

    if (cyc[0]) tick();
    cpu_op(1'b1, 13'h0123, 8'hA5);
    if (cyc[0]) tick();
    vid_addr = 13'h0123;
    tick();
    check_eq("vid_a5", vdat, 8'hA5);

    if (!cyc[0]) tick();
    cpu_op(1'b0, 13'h1FFF, 8'h00);
    check_eq("rd_1fff", rdat, 8'h3C);
    repeat (3) tick();
    check_eq("rd_1fff_hold", rdat, 8'h3C);

    // Back-to-back writes with cpu_req held across ACK, video walking underneath.
    if (cyc[0]) tick();
    vid_walk = 1'b1;
    vid_addr = 13'h0000;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0008; cpu_wdata = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      n = 0;
      do begin tick(); n++; end while (!ack && n < 10);
      if (k == 0) check_eq("b2b_first", n, 2);
      else check_eq("b2b_period", n, 4);
      model[cpu_addr] = cpu_wdata;
      known[cpu_addr] = 1'b1;
      cpu_addr = cpu_addr + 13'd1;
      cpu_wdata = 8'($urandom);
    end
    cpu_req = 1'b0;
    tick();
    repeat (20) tick();
    vid_walk = 1'b0;

    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      cpu_op(1'($urandom_range(0, 1)), 13'($urandom_range(0, 31)), 8'($urandom));
    end

    // Reset during the PEND slot of a write: no ack, old byte survives.
    cpu_op(1'b1, 13'h0010, 8'h11);
    if (cyc[0]) tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0010; cpu_wdata = 8'h99;
    tick();
    rst_b = 1'b1;
    acks = 0;
    repeat (3) begin
      tick();
      if (ack) acks++;
    end
    cpu_req = 1'b0;
    check_eq("rst_no_ack", acks, 0);
    release_reset(1'b0);
    check_reset(1'b0);
    cpu_op(1'b0, 13'h0010, 8'h00);
    check_eq("rst_wr_supp", rdat, 8'h11);
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
